// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces one push-button and NUM_SW
// slide switches. A shared prescaler produces a sample tick every TICK_DIV
// clocks. Each channel accepts a new level only after STABLE_TICKS
// consecutive differing samples. It reports a button-press interrupt and a
// one-cycle "any switch changed" pulse.
//
// Optional feature: define INPUT_CONDITIONER_IRQ_HOLD_EN to make btn_irq_o a
// sticky request that is cleared by irq_ack_i. When the macro is undefined,
// btn_irq_o is a one-cycle pulse and irq_ack_i is ignored.
module input_conditioner #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int NUM_SW       = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              btn_i,
  input  logic [NUM_SW-1:0] sw_i,
  input  logic              irq_ack_i,
  output logic              btn_level_o,
  output logic              btn_irq_o,
  output logic [NUM_SW-1:0] sw_o,
  output logic              sw_changed_o
);

  // Channel 0 is the button; channels 1..NUM_SW are the switches.
  localparam int               NUM_CH     = NUM_SW + 1;
  localparam int               PRE_W      = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0]       STABLE_CNT = 4'(STABLE_TICKS);

  logic [NUM_CH-1:0]      raw;
  logic [NUM_CH-1:0]      sync_p0;
  logic [NUM_CH-1:0]      sync_p1;
  logic [PRE_W-1:0]       pre_cnt;
  logic                   tick;
  logic [NUM_CH-1:0]      level;
  logic [NUM_CH-1:0]      level_nxt;
  logic [NUM_CH-1:0][3:0] cnt;
  logic [NUM_CH-1:0][3:0] cnt_nxt;
  logic                   btn_rise;
  logic                   sw_toggle;
  logic                   sw_chg_p2;

  // Next value of a stability counter after one more differing sample.
  function automatic logic [3:0] cnt_inc(input logic [3:0] c);
    return c + 4'd1;
  endfunction

  assign raw = {sw_i, btn_i};

  // ---- stage p0/p1: two-flop synchronizer for every raw input ----
  // Bring the asynchronous inputs into the clk_i domain.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Free-running sample prescaler. The tick is the single cycle at its top count.
  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  // Per-channel debounce decision, evaluated only on a sample tick.
  // An equal sample clears the counter, so short glitches never accumulate.
  always_comb begin
    level_nxt = level;
    cnt_nxt   = cnt;
    if (tick) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_p1[i] == level[i]) begin
          cnt_nxt[i] = 4'd0;
        end else if (cnt_inc(cnt[i]) == STABLE_CNT) begin
          cnt_nxt[i]   = 4'd0;
          level_nxt[i] = ~level[i];
        end else begin
          cnt_nxt[i] = cnt_inc(cnt[i]);
        end
      end
    end
  end

  assign btn_rise  = level_nxt[0] & ~level[0];
  assign sw_toggle = |(level_nxt[NUM_CH-1:1] ^ level[NUM_CH-1:1]);

  // ---- stage p2: debounced levels and stability counters ----
  // Commit the debounce decision and note whether any switch moved.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      level     <= '0;
      cnt       <= '0;
      sw_chg_p2 <= 1'b0;
    end else begin
      level     <= level_nxt;
      cnt       <= cnt_nxt;
      sw_chg_p2 <= sw_toggle;
    end
  end

  // ---- stage p3: change pulse, one cycle after sw_o moves ----
  // One pulse per tick, however many switch bits changed together.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sw_changed_o <= 1'b0;
    end else begin
      sw_changed_o <= sw_chg_p2;
    end
  end

`ifdef INPUT_CONDITIONER_IRQ_HOLD_EN
  // Sticky press request. A new press wins over a simultaneous ack.
  // Further presses merge into the pending request.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_irq_o <= 1'b0;
    end else if (btn_rise) begin
      btn_irq_o <= 1'b1;
    end else if (irq_ack_i) begin
      btn_irq_o <= 1'b0;
    end
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack_i;

  // One-cycle press pulse, aligned with the rising debounced level.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      btn_irq_o <= 1'b0;
    end else begin
      btn_irq_o <= btn_rise;
    end
  end
`endif

  assign btn_level_o = level[0];
  assign sw_o        = level[NUM_CH-1:1];

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner with TICK_DIV=4 and STABLE_TICKS=3.
// Directed scenarios come first, then a randomized run. The randomized run
// is compared every cycle against a behavioural model of the debounce rules.
module tb_input_conditioner;

  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int NUM_SW       = 16;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              btn;
  logic [NUM_SW-1:0] sw;
  logic              ack;
  logic              btn_level;
  logic              btn_irq;
  logic [NUM_SW-1:0] sw_out;
  logic              sw_changed;

  int n_vec  = 0;
  int n_fail = 0;

  input_conditioner #(
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS),
    .NUM_SW      (NUM_SW)
  ) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .btn_i       (btn),
    .sw_i        (sw),
    .irq_ack_i   (ack),
    .btn_level_o (btn_level),
    .btn_irq_o   (btn_irq),
    .sw_o        (sw_out),
    .sw_changed_o(sw_changed)
  );

  always #5 clk = ~clk;

  // Reference model. The model keeps the two most recent raw inputs as the
  // synchronizer delay. A sample is taken every TICK_DIV-th clock after reset.
  // For each channel it counts how many tick samples in a row disagreed with
  // the accepted level.
  bit [NUM_SW:0] m_s1      = '0;
  bit [NUM_SW:0] m_s2      = '0;
  bit [NUM_SW:0] m_lvl     = '0;
  int            m_run [NUM_SW+1];
  int            m_cyc     = 0;
  bit            m_irq     = 1'b0;
  bit            m_chg     = 1'b0;
  bit            m_chg_pend = 1'b0;

  always @(posedge clk or negedge arst_n) begin : model
    bit            smp_tick;
    bit            rose;
    bit            any_sw;
    bit [NUM_SW:0] samp;
    if (!arst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_cyc = 0;
      m_irq = 1'b0; m_chg = 1'b0; m_chg_pend = 1'b0;
      for (int i = 0; i <= NUM_SW; i++) m_run[i] = 0;
    end else begin
      samp     = m_s2;
      m_s2     = m_s1;
      m_s1     = {sw, btn};
      smp_tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
      m_cyc++;
      rose   = 1'b0;
      any_sw = 1'b0;
      m_chg  = m_chg_pend;
      if (smp_tick) begin
        for (int i = 0; i <= NUM_SW; i++) begin
          if (samp[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == STABLE_TICKS) begin
              m_lvl[i] = ~m_lvl[i];
              m_run[i] = 0;
              if (i == 0 && m_lvl[0]) rose = 1'b1;
              if (i > 0) any_sw = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_chg_pend = any_sw;
`ifdef INPUT_CONDITIONER_IRQ_HOLD_EN
      if (rose) m_irq = 1'b1;
      else if (ack) m_irq = 1'b0;
`else
      m_irq = rose;
`endif
    end
  end

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit bad_lvl, bad_irq, bad_sw, bad_chg;
    arst_n = 1'b0; btn = 1'b0; sw = '0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL reset_btn_level got %b want 0", btn_level); end
    n_vec++; if (btn_irq !== 1'b0) begin n_fail++; $display("FAIL reset_btn_irq got %b want 0", btn_irq); end
    n_vec++; if (sw_out !== '0) begin n_fail++; $display("FAIL reset_sw got %h want 0", sw_out); end
    n_vec++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL reset_sw_changed got %b want 0", sw_changed); end
    arst_n = 1'b1;
    bad_lvl = 0; bad_irq = 0; bad_sw = 0; bad_chg = 0;
    repeat (200) begin
      step();
      bad_lvl |= (btn_level !== 1'b0);
      bad_irq |= (btn_irq !== 1'b0);
      bad_sw  |= (sw_out !== '0);
      bad_chg |= (sw_changed !== 1'b0);
    end
    n_vec++; if (bad_lvl) begin n_fail++; $display("FAIL idle_btn_level saw nonzero want 0"); end
    n_vec++; if (bad_irq) begin n_fail++; $display("FAIL idle_btn_irq saw nonzero want 0"); end
    n_vec++; if (bad_sw) begin n_fail++; $display("FAIL idle_sw saw nonzero want 0"); end
    n_vec++; if (bad_chg) begin n_fail++; $display("FAIL idle_sw_changed saw nonzero want 0"); end
  endtask

  task automatic test_glitch();
    bit saw_lvl, saw_irq;
    btn = 1'b1;
    repeat (6) step();
    btn = 1'b0;
    saw_lvl = 0; saw_irq = 0;
    repeat (40) begin
      step();
      saw_lvl |= (btn_level !== 1'b0);
      saw_irq |= (btn_irq !== 1'b0);
    end
    n_vec++; if (saw_lvl) begin n_fail++; $display("FAIL glitch_level got 1 want 0"); end
    n_vec++; if (saw_irq) begin n_fail++; $display("FAIL glitch_irq got 1 want 0"); end
  endtask

  task automatic test_btn_press();
    int lat = 0;
    int irq_n = 0;
    btn = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (btn_level === 1'b1 && lat == 0) lat = n;
      if (btn_irq === 1'b1) irq_n++;
    end
    n_vec++; if (lat < 11 || lat > 15) begin n_fail++; $display("FAIL press_latency got %0d want 11..15", lat); end
`ifdef INPUT_CONDITIONER_IRQ_HOLD_EN
    n_vec++; if (irq_n != 40 - lat + 1) begin n_fail++; $display("FAIL press_irq_held got %0d want %0d", irq_n, 40 - lat + 1); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_vec++; if (btn_irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_ack got %b want 0", btn_irq); end
`else
    n_vec++; if (irq_n != 1) begin n_fail++; $display("FAIL press_irq_cycles got %0d want 1", irq_n); end
`endif
  endtask

  task automatic test_btn_release();
    bit saw_irq = 0;
    btn = 1'b0;
    repeat (40) begin
      step();
      saw_irq |= (btn_irq !== 1'b0);
    end
    n_vec++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL release_level got %b want 0", btn_level); end
    n_vec++; if (saw_irq) begin n_fail++; $display("FAIL release_irq got 1 want 0"); end
  endtask

`ifdef INPUT_CONDITIONER_IRQ_HOLD_EN
  task automatic test_irq_hold();
    bit dropped = 0;
    bit late = 0;
    int waited = 0;
    btn = 1'b1;
    while (btn_level !== 1'b1 && waited < 20) begin step(); waited++; end
    n_vec++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL hold_first_press got %b want 1", btn_level); end
    repeat (50) begin step(); dropped |= (btn_irq !== 1'b1); end
    btn = 1'b0;
    repeat (20) begin step(); dropped |= (btn_irq !== 1'b1); end
    btn = 1'b1;
    repeat (20) begin step(); dropped |= (btn_irq !== 1'b1); end
    n_vec++; if (btn_level !== 1'b1) begin n_fail++; $display("FAIL hold_second_press got %b want 1", btn_level); end
    n_vec++; if (dropped) begin n_fail++; $display("FAIL hold_pending got a low cycle want continuous 1"); end
    ack = 1'b1;
    n_vec++; if (btn_irq !== 1'b1) begin n_fail++; $display("FAIL hold_during_ack got %b want 1", btn_irq); end
    step();
    ack = 1'b0;
    n_vec++; if (btn_irq !== 1'b0) begin n_fail++; $display("FAIL hold_after_ack got %b want 0", btn_irq); end
    repeat (20) begin step(); late |= (btn_irq !== 1'b0); end
    n_vec++; if (late) begin n_fail++; $display("FAIL hold_stays_clear got 1 want 0"); end
  endtask
`endif

  task automatic test_switches();
    int chg_idx = -1;
    int pulse_idx = -1;
    int pulses = 0;
    logic [NUM_SW-1:0] prev;
    prev = sw_out;
    sw = 16'h8001;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (sw_out !== prev && chg_idx < 0) chg_idx = n;
      if (sw_changed === 1'b1) begin pulses++; if (pulse_idx < 0) pulse_idx = n; end
      prev = sw_out;
    end
    n_vec++; if (sw_out !== 16'h8001) begin n_fail++; $display("FAIL sw_value got %h want 8001", sw_out); end
    n_vec++; if (pulses != 1) begin n_fail++; $display("FAIL sw_pulse_count got %0d want 1", pulses); end
    n_vec++; if (chg_idx < 0 || pulse_idx != chg_idx + 1) begin n_fail++; $display("FAIL sw_pulse_timing got %0d want %0d", pulse_idx, chg_idx + 1); end
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    int irq_n = 0;
    int pulses = 0;
    btn = 1'b0;
    repeat (30) step();
    btn = 1'b1;
    repeat (7) step();
    n_vec++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL mid_pre_reset_level got %b want 0", btn_level); end
    arst_n = 1'b0;
    #1;
    n_vec++; if (btn_level !== 1'b0) begin n_fail++; $display("FAIL mid_reset_level got %b want 0", btn_level); end
    n_vec++; if (sw_out !== '0) begin n_fail++; $display("FAIL mid_reset_sw got %h want 0", sw_out); end
    n_vec++; if (btn_irq !== 1'b0) begin n_fail++; $display("FAIL mid_reset_irq got %b want 0", btn_irq); end
    n_vec++; if (sw_changed !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sw_changed got %b want 0", sw_changed); end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (btn_level === 1'b1 && lat == 0) lat = n;
      if (btn_irq === 1'b1) irq_n++;
      if (sw_changed === 1'b1) pulses++;
    end
    // The prescaler restarts at 0, so the third sample tick lands exactly on
    // clock STABLE_TICKS*TICK_DIV after release.
    n_vec++; if (lat != STABLE_TICKS * TICK_DIV) begin n_fail++; $display("FAIL mid_restart_latency got %0d want %0d", lat, STABLE_TICKS * TICK_DIV); end
    n_vec++; if (sw_out !== 16'h8001) begin n_fail++; $display("FAIL mid_restart_sw got %h want 8001", sw_out); end
    n_vec++; if (pulses != 1) begin n_fail++; $display("FAIL mid_restart_sw_pulses got %0d want 1", pulses); end
`ifdef INPUT_CONDITIONER_IRQ_HOLD_EN
    n_vec++; if (btn_irq !== 1'b1) begin n_fail++; $display("FAIL mid_restart_irq got %b want 1", btn_irq); end
    ack = 1'b1;
    step();
    ack = 1'b0;
`else
    n_vec++; if (irq_n != 1) begin n_fail++; $display("FAIL mid_restart_irq got %0d want 1", irq_n); end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      n_vec++; if (btn_level !== m_lvl[0]) begin n_fail++; $display("FAIL rnd_btn_level cyc %0d got %b want %b", c, btn_level, m_lvl[0]); end
      n_vec++; if (sw_out !== m_lvl[NUM_SW:1]) begin n_fail++; $display("FAIL rnd_sw cyc %0d got %h want %h", c, sw_out, m_lvl[NUM_SW:1]); end
      n_vec++; if (btn_irq !== m_irq) begin n_fail++; $display("FAIL rnd_btn_irq cyc %0d got %b want %b", c, btn_irq, m_irq); end
      n_vec++; if (sw_changed !== m_chg) begin n_fail++; $display("FAIL rnd_sw_changed cyc %0d got %b want %b", c, sw_changed, m_chg); end
      step();
      if ($urandom_range(0, 9) == 0) btn = ~btn;
      if ($urandom_range(0, 11) == 0) sw = sw ^ (NUM_SW'(1) << $urandom_range(0, NUM_SW - 1));
      if ($urandom_range(0, 39) == 0) sw = sw ^ NUM_SW'($urandom);
      ack = ($urandom_range(0, 7) == 0);
    end
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_btn_press();
    test_btn_release();
`ifdef INPUT_CONDITIONER_IRQ_HOLD_EN
    test_irq_hold();
`endif
    test_switches();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
